pre_if_stage: RTL and testbench
===============================

// Module: pre_if_stage
// PURPOSE
//  Fetch-request (pre-IF) stage, directly upstream of IF_stage. Generates next PC
//  (sequential or branch redirect), drives instruction-SRAM read requests, and hands
//  IF the fetched PC and instruction. Buffers redirects and SRAM read data across
//  IF back-pressure, so no fetch or branch target is lost while IF is stalled.
// PARAMETERS
//  RESET_PC   32'h1c000000   address of the first fetch after reset
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high reset
//  fs_allow_in      in   1   IF accepts a new instruction at this edge
//  br_taken         in   1   redirect request (one-cycle pulse from ID/EX)
//  br_target        in   32  redirect target, valid with br_taken
//  to_fs_valid      out  1   instruction issued this cycle is valid for IF
//  fs_pc            out  32  PC of the instruction currently returned to IF
//  fs_inst          out  32  instruction word for fs_pc (to IF inst_sram_rdata input)
//  inst_sram_en     out  1   SRAM read enable
//  inst_sram_we     out  4   SRAM byte write enables, always 4'b0
//  inst_sram_addr   out  32  SRAM read address
//  inst_sram_wdata  out  32  always 32'b0
//  inst_sram_rdata  in   32  SRAM read data, valid one cycle after the request
// BEHAVIOUR
//  - Clock clk, reset is synchronous and active-high; all state updates on posedge clk.
//  - State: fetch_pc[31:0], br_pend, br_pend_tgt[31:0], rdata_fresh, ibuf_valid,
//    ibuf_data[31:0].
//  - Reset values: fetch_pc=RESET_PC-4, br_pend=0, br_pend_tgt=0, rdata_fresh=0,
//    ibuf_valid=0, ibuf_data=0. During reset: inst_sram_en=0, to_fs_valid=0.
//  - nextpc (comb): br_taken ? br_target : br_pend ? br_pend_tgt : fetch_pc+4
//    (32-bit add, wraps mod 2^32). A live br_taken has priority over br_pend.
//  - req_fire = !reset && fs_allow_in. inst_sram_en = req_fire. inst_sram_addr = nextpc.
//  - to_fs_valid = req_fire.
//  - On req_fire:
//    fetch_pc <= nextpc; br_pend <= 0; rdata_fresh <= 1; ibuf_valid <= 0.
//  - Without req_fire: rdata_fresh <= 0.
//  - Redirect while IF stalled: br_taken && !req_fire -> br_pend <= 1,
//    br_pend_tgt <= br_target. A later br_taken overwrites the pending target.
//  - fs_pc = fetch_pc. Latency: request at cycle t; fs_pc/fs_inst valid at t+1.
//  - Inst buffer: if rdata_fresh && !fs_allow_in && !ibuf_valid,
//    then ibuf_valid <= 1 and ibuf_data <= inst_sram_rdata.
//    fs_inst = ibuf_valid ? ibuf_data : inst_sram_rdata.
//    Result: the word returned for fetch_pc is held stable for any stall length.
//  - Simultaneous req_fire and br_taken: request goes to br_target this cycle.
//    br_pend is not set. Killing the wrong-path word already in IF belongs to IF
//    (br_taken_cancel).
//  - Reset mid-stall: pending redirect and buffered word are discarded.
//    First request after reset release goes to RESET_PC.
//  - No alignment check; addr[1:0] passed through unchanged.
// TESTING
//  1 reset 3 cycles, release, fs_allow_in=1 -> addrs 0x1c000000, 0x1c000004, 0x1c000008
//    on consecutive cycles; fs_pc lags the address by one cycle; inst_sram_we=0.
//  2 request 0x1c000004, then fs_allow_in=0 for 4 cycles, SRAM rdata changes to junk
//    after 1 cycle -> fs_inst holds the word for 0x1c000004; inst_sram_en=0 throughout;
//    on release next addr 0x1c000008.
//  3 fs_allow_in=1, br_taken=1, br_target=0x1c000100 -> same-cycle addr 0x1c000100;
//    next cycle fs_pc=0x1c000100; next addr 0x1c000104.
//  4 fs_allow_in=0, br_taken pulse target 0x1c000200, allow returns 3 cycles later ->
//    first addr 0x1c000200; br_pend clears.
//  5 two redirects while stalled (0x1c000300 then 0x1c000400) -> first request 0x1c000400.
//  6 assert reset while br_pend=1 and ibuf_valid=1 -> after release, first addr 0x1c000000;
//    ibuf not used.

Source files
------------

// File: rtl/pre_if_stage.sv
// -----------------------------------------------------------------------------
// pre_if_stage
//   Fetch-request stage that sits directly upstream of IF. Each cycle it picks
//   the next PC (sequential, live redirect, or a redirect remembered while IF
//   was stalled), issues an instruction-SRAM read for it, and presents IF with
//   the PC of the previously issued request and that request's instruction word.
//   Redirects and returned SRAM words are held across IF back-pressure so that
//   neither a branch target nor a fetched word is lost during a stall.
//
// Parameters
//   RESET_PC         address of the first fetch after reset
//
// Ports
//   clk              clock
//   reset            synchronous, active-high reset
//   fs_allow_in      IF accepts a new instruction at this edge
//   br_taken         redirect request (one-cycle pulse)
//   br_target        redirect target, valid with br_taken
//   to_fs_valid      request issued this cycle is valid for IF
//   fs_pc            PC of the instruction currently returned to IF
//   fs_inst          instruction word for fs_pc
//   inst_sram_en     SRAM read enable
//   inst_sram_we     SRAM byte write enables (never written)
//   inst_sram_addr   SRAM read address
//   inst_sram_wdata  SRAM write data (never written)
//   inst_sram_rdata  SRAM read data, valid one cycle after the request
// -----------------------------------------------------------------------------
module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allow_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        to_fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] fetch_pc_reg;
  logic        br_pend_reg;
  logic [31:0] br_pend_tgt_reg;
  logic        rdata_fresh_reg;
  logic        ibuf_valid_reg;
  logic [31:0] ibuf_data_reg;

  logic        req_fire;
  logic [31:0] nextpc;

  // A live redirect beats a remembered one; otherwise fetch sequentially.
  // Starting fetch_pc at RESET_PC-4 makes the first sequential fetch RESET_PC.
  always_comb begin
    if (br_taken) begin
      nextpc = br_target;
    end else if (br_pend_reg) begin
      nextpc = br_pend_tgt_reg;
    end else begin
      nextpc = fetch_pc_reg + 32'd4;
    end
  end

  assign req_fire        = !reset && fs_allow_in;
  assign inst_sram_en    = req_fire;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;
  assign to_fs_valid     = req_fire;

  assign fs_pc   = fetch_pc_reg;
  // Once a stall has captured the returned word, IF keeps seeing it even
  // though the SRAM output may have moved on.
  assign fs_inst = ibuf_valid_reg ? ibuf_data_reg : inst_sram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC - 32'd4;
      br_pend_reg     <= 1'b0;
      br_pend_tgt_reg <= 32'h0000_0000;
      rdata_fresh_reg <= 1'b0;
      ibuf_valid_reg  <= 1'b0;
      ibuf_data_reg   <= 32'h0000_0000;
    end else begin
      if (req_fire) begin
        fetch_pc_reg    <= nextpc;
        br_pend_reg     <= 1'b0;
        rdata_fresh_reg <= 1'b1;
        ibuf_valid_reg  <= 1'b0;
      end else begin
        rdata_fresh_reg <= 1'b0;
        // Remember the redirect until IF can take a request; a newer one wins.
        if (br_taken) begin
          br_pend_reg     <= 1'b1;
          br_pend_tgt_reg <= br_target;
        end
      end

      // The SRAM word is only guaranteed in the cycle right after the request,
      // so capture it on the first stalled cycle.
      if (rdata_fresh_reg && !fs_allow_in && !ibuf_valid_reg) begin
        ibuf_valid_reg <= 1'b1;
        ibuf_data_reg  <= inst_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
module tb_pre_if_stage;

  localparam logic [31:0] JUNK = 32'hBADB_AD00;

  logic        clk;
  logic        reset;
  logic        fs_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int checks = 0;
  int errors = 0;

  pre_if_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allow_in     (fs_allow_in),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .to_fs_valid     (to_fs_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: the word stored at address a is ~a; when not read, the output
  // goes to junk so that only a buffered word can survive a stall.
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? ~inst_sram_addr : JUNK;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return ~a;
  endfunction

  typedef struct {
    logic        rst;
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    logic        exp_en;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        chk_pc;
    logic [31:0] exp_pc;
    logic        chk_inst;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic allow, input logic br,
                     input logic [31:0] tgt, input logic exp_en,
                     input logic chk_addr, input logic [31:0] exp_addr,
                     input logic chk_pc, input logic [31:0] exp_pc,
                     input logic chk_inst, input logic [31:0] exp_inst);
    vec_t v;
    v.rst = rst; v.allow = allow; v.br = br; v.tgt = tgt; v.exp_en = exp_en;
    v.chk_addr = chk_addr; v.exp_addr = exp_addr;
    v.chk_pc = chk_pc; v.exp_pc = exp_pc;
    v.chk_inst = chk_inst; v.exp_inst = exp_inst;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step_check(input string tag, input logic exp_en, input logic chk_addr,
                            input logic [31:0] exp_addr, input logic chk_pc,
                            input logic [31:0] exp_pc, input logic chk_inst,
                            input logic [31:0] exp_inst);
    @(negedge clk);
    check({tag, " en"}, {31'b0, inst_sram_en}, {31'b0, exp_en});
    check({tag, " valid"}, {31'b0, to_fs_valid}, {31'b0, exp_en});
    check({tag, " we"}, {28'b0, inst_sram_we}, 32'h0);
    check({tag, " wdata"}, inst_sram_wdata, 32'h0);
    if (chk_addr) check({tag, " addr"}, inst_sram_addr, exp_addr);
    if (chk_pc)   check({tag, " fs_pc"}, fs_pc, exp_pc);
    if (chk_inst) check({tag, " fs_inst"}, fs_inst, exp_inst);
    $display("%s t=%0t rst=%0b allow=%0b br=%0b en=%0b addr=%08h fs_pc=%08h fs_inst=%08h",
             tag, $time, reset, fs_allow_in, br_taken, inst_sram_en, inst_sram_addr,
             fs_pc, fs_inst);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fs_allow_in = 1'b1; br_taken = 1'b0; br_target = 32'h0;

    // reset 3 cycles
    add(1,1,0,0,            0, 0,0,            0,0,            0,0);
    add(1,1,0,0,            0, 0,0,            1,32'h1bfffffc, 0,0);
    add(1,1,0,0,            0, 0,0,            1,32'h1bfffffc, 1,JUNK);
    // sequential fetch
    add(0,1,0,0,            1, 1,32'h1c000000, 1,32'h1bfffffc, 0,0);
    add(0,1,0,0,            1, 1,32'h1c000004, 1,32'h1c000000, 1,word(32'h1c000000));
    // stall 4 cycles holding word for 0x1c000004
    add(0,0,0,0,            0, 1,32'h1c000008, 1,32'h1c000004, 1,word(32'h1c000004));
    add(0,0,0,0,            0, 1,32'h1c000008, 1,32'h1c000004, 1,word(32'h1c000004));
    add(0,0,0,0,            0, 1,32'h1c000008, 1,32'h1c000004, 1,word(32'h1c000004));
    add(0,0,0,0,            0, 1,32'h1c000008, 1,32'h1c000004, 1,word(32'h1c000004));
    add(0,1,0,0,            1, 1,32'h1c000008, 1,32'h1c000004, 1,word(32'h1c000004));
    // same-cycle redirect
    add(0,1,1,32'h1c000100, 1, 1,32'h1c000100, 1,32'h1c000008, 1,word(32'h1c000008));
    add(0,1,0,0,            1, 1,32'h1c000104, 1,32'h1c000100, 1,word(32'h1c000100));
    // redirect during stall
    add(0,0,1,32'h1c000200, 0, 1,32'h1c000200, 1,32'h1c000104, 1,word(32'h1c000104));
    add(0,0,0,0,            0, 1,32'h1c000200, 1,32'h1c000104, 1,word(32'h1c000104));
    add(0,0,0,0,            0, 1,32'h1c000200, 1,32'h1c000104, 1,word(32'h1c000104));
    add(0,1,0,0,            1, 1,32'h1c000200, 1,32'h1c000104, 1,word(32'h1c000104));
    add(0,1,0,0,            1, 1,32'h1c000204, 1,32'h1c000200, 1,word(32'h1c000200));
    // two redirects while stalled, last wins
    add(0,0,1,32'h1c000300, 0, 1,32'h1c000300, 1,32'h1c000204, 1,word(32'h1c000204));
    add(0,0,0,0,            0, 1,32'h1c000300, 1,32'h1c000204, 1,word(32'h1c000204));
    add(0,0,1,32'h1c000400, 0, 1,32'h1c000400, 1,32'h1c000204, 1,word(32'h1c000204));
    add(0,0,0,0,            0, 1,32'h1c000400, 1,32'h1c000204, 1,word(32'h1c000204));
    add(0,1,0,0,            1, 1,32'h1c000400, 1,32'h1c000204, 1,word(32'h1c000204));
    add(0,1,0,0,            1, 1,32'h1c000404, 1,32'h1c000400, 1,word(32'h1c000400));
    // reset with br_pend and ibuf_valid set
    add(0,0,1,32'h1c000500, 0, 1,32'h1c000500, 1,32'h1c000404, 1,word(32'h1c000404));
    add(0,0,0,0,            0, 1,32'h1c000500, 1,32'h1c000404, 1,word(32'h1c000404));
    add(1,0,0,0,            0, 0,0,            1,32'h1c000404, 0,0);
    add(1,1,0,0,            0, 0,0,            1,32'h1bfffffc, 1,JUNK);
    add(0,1,0,0,            1, 1,32'h1c000000, 1,32'h1bfffffc, 1,JUNK);
    add(0,1,0,0,            1, 1,32'h1c000004, 1,32'h1c000000, 1,word(32'h1c000000));
    // wrap-around and unaligned pass-through
    add(0,1,1,32'hfffffffc, 1, 1,32'hfffffffc, 1,32'h1c000004, 1,word(32'h1c000004));
    add(0,1,0,0,            1, 1,32'h00000000, 1,32'hfffffffc, 1,word(32'hfffffffc));
    add(0,1,1,32'h1c000003, 1, 1,32'h1c000003, 1,32'h00000000, 1,word(32'h00000000));
    add(0,1,0,0,            1, 1,32'h1c000007, 1,32'h1c000003, 1,word(32'h1c000003));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset       = vecs[i].rst;
      fs_allow_in = vecs[i].allow;
      br_taken    = vecs[i].br;
      br_target   = vecs[i].tgt;
      step_check($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].chk_addr, vecs[i].exp_addr,
                 vecs[i].chk_pc, vecs[i].exp_pc, vecs[i].chk_inst, vecs[i].exp_inst);
    end

    // Long stall: the word for 0x1c000007 must be held for 20 cycles.
    reset = 1'b0; fs_allow_in = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    for (int k = 0; k < 20; k++) begin
      step_check($sformatf("stall%0d", k), 1'b0, 1'b1, 32'h1c00000b,
                 1'b1, 32'h1c000007, 1'b1, word(32'h1c000007));
    end
    fs_allow_in = 1'b1;
    step_check("release", 1'b1, 1'b1, 32'h1c00000b, 1'b1, 32'h1c000007,
               1'b1, word(32'h1c000007));
    step_check("after", 1'b1, 1'b1, 32'h1c00000f, 1'b1, 32'h1c00000b,
               1'b1, word(32'h1c00000b));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
